// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and counter sizing for the data-memory responder
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte/half/word lane steering, load extension and access legality
//   in:  we, funct3, lane (addr[1:0]), wdata (right-aligned), old_word
//   out: store_word (merged), load_word (extended), bad (misaligned or illegal funct3)
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] old_word,
   output logic [31:0] store_word,
   output logic [31:0] load_word,
   output logic        bad
);
   logic [4:0]  bsh, hsh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask, data;
   always_comb begin
      bsh        = {lane, 3'b000};
      hsh        = {lane[1], 4'b0000};
      b          = 8'(old_word >> bsh);
      h          = 16'(old_word >> hsh);
      load_word  = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
                   (funct3 == F3_H)  ? {{16{h[15]}}, h} :
                   (funct3 == F3_BU) ? {24'b0, b} :
                   (funct3 == F3_HU) ? {16'b0, h} : old_word;
      mask       = (funct3 == F3_B) ? 32'h0000_00FF << bsh :
                   (funct3 == F3_H) ? 32'h0000_FFFF << hsh : 32'hFFFF_FFFF;
      data       = (funct3 == F3_B) ? {24'b0, wdata[7:0]} << bsh :
                   (funct3 == F3_H) ? {16'b0, wdata[15:0]} << hsh : wdata;
      store_word = (old_word & ~mask) | (data & mask);
      bad        = (we ? (funct3[2] | (funct3[1:0] == 2'b11))
                       : ((funct3[1:0] == 2'b11) | (funct3[2] & funct3[1])))
                 | ((funct3[1:0] == 2'b01) & lane[0])
                 | ((funct3[1:0] == 2'b10) & (lane != 2'b00));
   end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind valid/ready request and response channels
//   request:  req_valid/req_ready, req_we, req_addr, req_wdata, req_funct3
//   response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
//   reset is asynchronous active-low; storage contents are not reset
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [2:0]        req_funct3,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);
   localparam int CW = cnt_w(WAIT_CYCLES);
   localparam int IW = $clog2(DEPTH_WORDS);
   state_t            state, state_n;
   logic [CW-1:0]     cnt, cnt_n;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [31:0]       a_wdata;
   logic [2:0]        a_f3;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [31:0]       old_word, store_word, load_word, rsp_rdata_n;
   logic              bad, err, accept, req_ready_n, rsp_valid_n, rsp_err_n;
   assign accept   = req_valid & req_ready;
   assign old_word = mem[a_addr[IW+1:2]];
   assign err      = bad | (a_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS));
   dmem_lane_align u_align (
      .we         (a_we),
      .funct3     (a_f3),
      .lane       (a_addr[1:0]),
      .wdata      (a_wdata),
      .old_word   (old_word),
      .store_word (store_word),
      .load_word  (load_word),
      .bad        (bad)
   );
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      req_ready_n = req_ready;
      rsp_valid_n = rsp_valid;
      rsp_rdata_n = rsp_rdata;
      rsp_err_n   = rsp_err;
      case (state)
         IDLE: begin
            req_ready_n = !accept;
            if (accept) begin
               state_n = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
               cnt_n   = CW'(WAIT_CYCLES);
            end
         end
         WAIT: begin
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) state_n = ACCESS;
         end
         ACCESS: begin
            state_n     = RESP;
            rsp_valid_n = 1'b1;
            rsp_err_n   = err;
            rsp_rdata_n = (err | a_we) ? 32'h0 : load_word;
         end
         RESP: begin
            if (rsp_ready) begin
               state_n     = IDLE;
               rsp_valid_n = 1'b0;
               req_ready_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         a_we      <= 1'b0;
         a_addr    <= '0;
         a_wdata   <= '0;
         a_f3      <= '0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         rsp_err   <= rsp_err_n;
         if (accept) begin
            a_we    <= req_we;
            a_addr  <= req_addr;
            a_wdata <= req_wdata;
            a_f3    <= req_funct3;
         end
      end
   end
   // reset forces IDLE asynchronously, so a store interrupted before ACCESS never lands
   always_ff @(posedge clk)
      if (state == ACCESS && a_we && !err) mem[a_addr[IW+1:2]] <= store_word;
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
   localparam int WC = 2;
   logic        clk = 0, reset = 0, req_valid = 0, req_we = 0, rsp_ready = 0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] req_addr = 0, req_wdata = 0, rsp_rdata;
   logic [2:0]  req_funct3 = 0;
   int          checks = 0, passed = 0;
   byte unsigned mb [256];
   logic [31:0] rd, prior;
   logic        e;
   int          n;

   always #5 clk = ~clk;

   dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(64), .WAIT_CYCLES(WC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // reference: byte-addressed memory of 256 bytes, access size and signedness from funct3
   task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [2:0] f3, output logic [31:0] rdv, output logic errv);
      int sz; bit sx; logic [31:0] v;
      sz = 0; sx = 0;
      case (f3)
         3'd0: begin sz = 1; sx = 1; end
         3'd1: begin sz = 2; sx = 1; end
         3'd2: sz = 4;
         3'd4: sz = 1;
         3'd5: sz = 2;
         default: sz = 0;
      endcase
      if (we && f3 > 3'd2) sz = 0;
      errv = 1; rdv = 0;
      if (sz != 0 && a < 256) begin
         if (int'(a) % sz == 0) begin
            errv = 0;
            if (we) for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
            else begin
               v = 0;
               for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[int'(a) + i];
               if (sx && sz < 4 && v[8*sz-1]) for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
               rdv = v;
            end
         end
      end
   endtask

   task automatic issue(input string tag, input logic we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3);
      int k;
      k = 0;
      while (req_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      chk({tag, "/req_ready"}, 32'(req_ready), 1);
      req_valid = 1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
      @(posedge clk); #1;
      req_valid = 0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      req_funct3 = 3'($urandom);
   endtask

   task automatic await_valid(output int cnt);
      cnt = 0;
      do begin @(posedge clk); cnt++; @(negedge clk); end
      while (rsp_valid !== 1'b1 && cnt < 40);
   endtask

   task automatic txn(input string tag, input logic we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [2:0] f3, input int hold, output logic [31:0] rdv, output logic errv);
      logic [31:0] erd; logic eerr; int lat;
      model(we, a, wd, f3, erd, eerr);
      issue(tag, we, a, wd, f3);
      await_valid(lat);
      chk({tag, "/latency"}, 32'(lat), 32'(WC + 1));
      chk({tag, "/rdata"}, rsp_rdata, erd);
      chk({tag, "/err"}, 32'(rsp_err), 32'(eerr));
      rdv = rsp_rdata; errv = rsp_err;
      repeat (hold) begin
         @(negedge clk);
         chk({tag, "/hold_valid"}, 32'(rsp_valid), 1);
         chk({tag, "/hold_rdata"}, rsp_rdata, erd);
         chk({tag, "/hold_req_ready"}, 32'(req_ready), 0);
      end
      chk({tag, "/req_ready_in_resp"}, 32'(req_ready), 0);
      rsp_ready = 1;
      @(posedge clk); #1;
      rsp_ready = 0;
      chk({tag, "/valid_drop"}, 32'(rsp_valid), 0);
      chk({tag, "/ready_back"}, 32'(req_ready), 1);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      chk("rst/req_ready", 32'(req_ready), 0);
      chk("rst/rsp_valid", 32'(rsp_valid), 0);
      chk("rst/rsp_rdata", rsp_rdata, 0);
      chk("rst/rsp_err", 32'(rsp_err), 0);
      reset = 1;
      @(posedge clk); #1;
      chk("rst/ready_rise", 32'(req_ready), 1);
      for (int w = 0; w < 64; w++) txn("init", 1, 32'(w * 4), $urandom, 3'd2, 0, rd, e);
      txn("sw10", 1, 32'h10, 32'hDEADBEEF, 3'd2, 0, rd, e);
      chk("sw10/rdata0", rd, 0);
      txn("lw10", 0, 32'h10, 0, 3'd2, 0, rd, e);
      chk("lw10/val", rd, 32'hDEADBEEF);
      txn("lb13", 0, 32'h13, 0, 3'd0, 0, rd, e);
      chk("lb13/val", rd, 32'hFFFFFFDE);
      txn("lbu13", 0, 32'h13, 0, 3'd4, 0, rd, e);
      chk("lbu13/val", rd, 32'h000000DE);
      txn("lh12", 0, 32'h12, 0, 3'd1, 0, rd, e);
      chk("lh12/val", rd, 32'hFFFFDEAD);
      txn("lhu10", 0, 32'h10, 0, 3'd5, 0, rd, e);
      chk("lhu10/val", rd, 32'h0000BEEF);
      txn("sb11", 1, 32'h11, 32'h12, 3'd0, 0, rd, e);
      txn("lw10b", 0, 32'h10, 0, 3'd2, 0, rd, e);
      chk("lw10b/val", rd, 32'hDEAD12EF);
      txn("lw12", 0, 32'h12, 0, 3'd2, 0, rd, e);
      chk("lw12/err", 32'(e), 1);
      chk("lw12/rdata0", rd, 0);
      txn("sh13", 1, 32'h13, 32'hFFFF, 3'd1, 0, rd, e);
      chk("sh13/err", 32'(e), 1);
      txn("lw10c", 0, 32'h10, 0, 3'd2, 0, rd, e);
      chk("lw10c/val", rd, 32'hDEAD12EF);
      txn("lw100", 0, 32'h100, 0, 3'd2, 0, rd, e);
      chk("lw100/err", 32'(e), 1);
      txn("ld011", 0, 32'h10, 0, 3'd3, 0, rd, e);
      chk("ld011/err", 32'(e), 1);
      txn("stall", 0, 32'h10, 0, 3'd2, 5, rd, e);
      chk("stall/val", rd, 32'hDEAD12EF);
      // store interrupted by reset during the wait states
      prior = {mb[35], mb[34], mb[33], mb[32]};
      issue("rstw", 1, 32'h20, 32'hCAFEF00D, 3'd2);
      @(negedge clk);
      reset = 0; #1;
      chk("rstw/req_ready", 32'(req_ready), 0);
      chk("rstw/rsp_valid", 32'(rsp_valid), 0);
      chk("rstw/rsp_rdata", rsp_rdata, 0);
      chk("rstw/rsp_err", 32'(rsp_err), 0);
      repeat (3) begin @(negedge clk); chk("rstw/held", 32'(req_ready), 0); end
      reset = 1;
      @(posedge clk); #1;
      chk("rstw/ready_rise", 32'(req_ready), 1);
      txn("lw20", 0, 32'h20, 0, 3'd2, 0, rd, e);
      chk("lw20/prior", rd, prior);
      // pending load response discarded by reset
      issue("rstr", 0, 32'h10, 0, 3'd2);
      await_valid(n);
      chk("rstr/valid", 32'(rsp_valid), 1);
      reset = 0; #1;
      chk("rstr/valid_clr", 32'(rsp_valid), 0);
      chk("rstr/rdata_clr", rsp_rdata, 0);
      @(negedge clk);
      reset = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 150; i++)
         txn("rand", 1'($urandom), 32'($urandom_range(0, 300)), $urandom, 3'($urandom),
             int'($urandom_range(0, 2)), rd, e);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory responder: the memory end of the core's load/store interface.
- Replaces the single-cycle data memory behind a valid/ready request channel and a valid/ready response channel.
- Inserts programmable wait states, steers byte/half/word lanes per RISC-V funct3, sign/zero-extends loads, and flags misaligned, illegal or out-of-range accesses.
- One outstanding request at a time.

Parameters:
- ADDR_W, 32, request address width.
- DEPTH_WORDS, 64, number of 32-bit storage words (power of two).
- WAIT_CYCLES, 2, wait states inserted between acceptance and array access (0 allowed).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_funct3  in  3  access size/sign, RISC-V load/store funct3 encoding.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  load result, extended; 0 for stores and errors.
- rsp_err  out  1  access faulted; no array side effect occurred.

Behaviour:
- FSM states: IDLE, WAIT, ACCESS, RESP.
- All outputs are registered.
- Reset (reset=0, async) forces IDLE, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and clears the wait counter. Storage contents are not reset.
- req_ready rises on the first clk edge after reset deasserts. It is 1 only in IDLE.
- Accept on an edge with req_valid & req_ready. At that edge:
  - capture we, addr, wdata, funct3;
  - set req_ready=0;
  - go to WAIT with counter=WAIT_CYCLES, or go directly to ACCESS if WAIT_CYCLES=0.
- WAIT: decrement the counter every edge; go to ACCESS on the edge where the counter reaches 0. Input request changes are ignored.
- ACCESS: one cycle. On its closing edge:
  - perform the store (if legal) or the load;
  - register rsp_rdata and rsp_err;
  - set rsp_valid=1;
  - go to RESP.
- Latency: rsp_valid is first high after the (WAIT_CYCLES+1)th edge following the accepting edge. With WAIT_CYCLES=2 this is the 3rd edge.
- RESP: rsp_valid, rsp_rdata and rsp_err stay stable until an edge with rsp_ready=1. On that edge:
  - rsp_valid=0, req_ready=1, go to IDLE;
  - the next request cannot be accepted in that same cycle (minimum 1 idle cycle between transactions).
- Address mapping:
  - word index = addr[ADDR_W-1:2], lane = addr[1:0], little-endian.
  - out of range if word index ≥ DEPTH_WORDS.
- Loads:
  - 000 LB: sign-extend byte at lane.
  - 001 LH: sign-extend half at addr[1]*2.
  - 010 LW: full word.
  - 100 LBU / 101 LHU: zero-extend.
  - 011, 110, 111: illegal.
- Stores:
  - 000 SB: wdata[7:0] to lane.
  - 001 SH: wdata[15:0] to half.
  - 010 SW: full word.
  - Any other funct3 is illegal.
  - Unwritten bytes of the word are preserved.
- Misaligned: half access with addr[0]=1; word access with addr[1:0]≠0.
- Error response: rsp_err=1, rsp_rdata=0, no array write, same latency as a legal access.
- Legal store response: rsp_err=0, rsp_rdata=0.
- Reset mid-operation: if reset asserts before the ACCESS closing edge, the store is dropped and memory is unchanged. Any pending response is discarded.
- Back-to-back store-then-load to the same address returns the newly stored data.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state enum;
  - the WAIT_CYCLES counter width function.
- One natural combinational sub-module, dmem_lane_align:
  - inputs: funct3, addr[1:0], wdata, old word;
  - outputs: merged store word, extended load value, misaligned/illegal flag.

Test Plan:
- Reset then SW addr 0x10, wdata 0xDEADBEEF, WAIT_CYCLES=2 → rsp_valid after the 3rd edge, rsp_err=0, rsp_rdata=0. Then LW 0x10 → rsp_rdata=0xDEADBEEF.
- After the previous test, LB 0x13 → 0xFFFFFFDE. LBU 0x13 → 0x000000DE. LH 0x12 → 0xFFFFDEAD. LHU 0x10 → 0x0000BEEF.
- SB 0x11, wdata 0x12 → a following LW 0x10 returns 0xDEAD12EF (other bytes preserved).
- LW 0x12 → rsp_err=1, rsp_rdata=0. SH 0x13 → rsp_err=1 and a following LW 0x10 is unchanged. LW 0x100 (word 64, DEPTH 64) → rsp_err=1. Load funct3=011 → rsp_err=1.
- Hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stay stable and req_ready stays 0. Raise rsp_ready → IDLE, req_ready=1 on the next edge.
- SW 0x20, 0xCAFEF00D, with reset pulsed low during WAIT → outputs clear immediately, req_ready=0 while in reset. A later LW 0x20 returns the prior contents, not 0xCAFEF00D.
